// File: rtl/riscv_periph_pkg.sv
// Shared definitions for the peripheral-bus initiator: bridge FSM states,
// address-window geometry and fixed slot assignments.
package riscv_periph_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR
  } state_e;

  localparam int unsigned ADDR_LOW_WIDTH = 12;

  localparam int unsigned SLV_GPIO  = 0;
  localparam int unsigned SLV_TIMER = 1;
  localparam int unsigned SLV_UART  = 2;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/riscv_apb_decoder.sv
// Address decoder: maps the address bits above the 4 KiB window to a one-hot
// slave select plus a hit flag; any window index >= NSLV is unmapped.
import riscv_periph_pkg::*;

module riscv_apb_decoder #(
  parameter int unsigned NSLV      = 4,
  parameter int unsigned HI_W      = 20,
  parameter int unsigned SLV_IDX_W = idx_width(NSLV)
) (
  input  logic [HI_W-1:0]      addr_hi_i,
  output logic                 hit_o,
  output logic [SLV_IDX_W-1:0] idx_o,
  output logic [NSLV-1:0]      sel_o
);

  // The whole upper field takes part in the hit test, so aliased windows
  // above the last slot report an error instead of wrapping onto a slave.
  always_comb begin
    hit_o = (addr_hi_i < HI_W'(NSLV));
    idx_o = addr_hi_i[SLV_IDX_W-1:0];
    sel_o = '0;
    for (int unsigned k = 0; k < NSLV; k++) begin
      sel_o[k] = hit_o && (idx_o == SLV_IDX_W'(k));
    end
  end

endmodule

// File: rtl/riscv_apb_bridge.sv
// Peripheral-bus initiator: turns single core requests into setup/access
// transfers, returns read data and flags accesses to unmapped windows.
import riscv_periph_pkg::*;

module riscv_apb_bridge #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NSLV    = 4,
  parameter int unsigned IDX_LSB = ADDR_LOW_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [XLEN-1:0]      addr_i,
  input  logic [XLEN-1:0]      wdata_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [XLEN-1:0]      rdata_o,
  output logic                 err_o,
  output logic [NSLV-1:0]      psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [XLEN-1:0]      paddr_o,
  output logic [XLEN-1:0]      pwdata_o,
  input  logic [NSLV*XLEN-1:0] prdata_i
);

  localparam int unsigned SLV_IDX_W = idx_width(NSLV);
  localparam int unsigned HI_W      = XLEN - IDX_LSB;

  state_e                 state_q;
  logic [SLV_IDX_W-1:0]   idx_q;
  logic [NSLV-1:0]        psel_q;
  logic                   penable_q;
  logic                   pwrite_q;
  logic [XLEN-1:0]        paddr_q;
  logic [XLEN-1:0]        pwdata_q;
  logic                   rvalid_q;
  logic                   err_q;
  logic [XLEN-1:0]        rdata_q;

  logic                   dec_hit;
  logic [SLV_IDX_W-1:0]   dec_idx;
  logic [NSLV-1:0]        dec_sel;
  logic [XLEN-1:0]        slot_rdata;

  riscv_apb_decoder #(
    .NSLV      (NSLV),
    .HI_W      (HI_W),
    .SLV_IDX_W (SLV_IDX_W)
  ) u_dec (
    .addr_hi_i (addr_i[XLEN-1:IDX_LSB]),
    .hit_o     (dec_hit),
    .idx_o     (dec_idx),
    .sel_o     (dec_sel)
  );

  always_comb begin
    slot_rdata = prdata_i[32'(idx_q)*XLEN +: XLEN];
  end

  // Bus-side registers double as the request latch; they are cleared on
  // leaving ACCESS so address/data read as zero whenever no slave is selected.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            if (dec_hit) begin
              state_q  <= ST_SETUP;
              idx_q    <= dec_idx;
              psel_q   <= dec_sel;
              pwrite_q <= we_i;
              paddr_q  <= addr_i;
              pwdata_q <= wdata_i;
            end else begin
              state_q <= ST_ERR;
            end
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          rvalid_q  <= 1'b1;
          rdata_q   <= pwrite_q ? '0 : slot_rdata;
          psel_q    <= '0;
          penable_q <= 1'b0;
          pwrite_q  <= 1'b0;
          paddr_q   <= '0;
          pwdata_q  <= '0;
          state_q   <= ST_IDLE;
        end
        ST_ERR: begin
          rvalid_q <= 1'b1;
          err_q    <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt_o     = rstn && (state_q == ST_IDLE);
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_riscv_apb_bridge.sv
// Directed and randomized checks of the peripheral-bus bridge against a
// transaction-level expectation built from address-window arithmetic.
module tb_riscv_apb_bridge;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NSLV = 4;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 req_i = 1'b0;
  logic                 we_i = 1'b0;
  logic [XLEN-1:0]      addr_i = '0;
  logic [XLEN-1:0]      wdata_i = '0;
  logic                 gnt_o;
  logic                 rvalid_o;
  logic [XLEN-1:0]      rdata_o;
  logic                 err_o;
  logic [NSLV-1:0]      psel_o;
  logic                 penable_o;
  logic                 pwrite_o;
  logic [XLEN-1:0]      paddr_o;
  logic [XLEN-1:0]      pwdata_o;
  logic [NSLV*XLEN-1:0] prdata_i = '0;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [XLEN-1:0] slot_val [NSLV];

  riscv_apb_bridge #(.XLEN(XLEN), .NSLV(NSLV), .IDX_LSB(12)) dut (
    .clk(clk), .rstn(rstn), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus_rules();
    chk("psel_onehot0", 32'($onehot0(psel_o)), 32'd1);
    chk("penable_needs_psel", 32'(penable_o && (psel_o == '0)), 32'd0);
  endtask

  task automatic load_slots();
    for (int k = 0; k < NSLV; k++) begin
      slot_val[k] = $urandom;
      prdata_i[k*XLEN +: XLEN] = slot_val[k];
    end
  endtask

  // One complete transfer, started from IDLE; expectations come from the
  // window number addr/4096 and the fixed 3-cycle / 2-cycle response latency.
  task automatic txn(input logic w, input logic [XLEN-1:0] a, input logic [XLEN-1:0] d);
    logic            mapped;
    int unsigned     idx;
    logic [NSLV-1:0] esel;
    logic [XLEN-1:0] erdata;
    int unsigned     waited;
    mapped = (a / 4096) < NSLV;
    idx    = mapped ? (a / 4096) : 0;
    esel   = mapped ? NSLV'(1 << idx) : '0;
    erdata = (mapped && !w) ? slot_val[idx] : '0;
    req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
    waited = 0;
    while (!gnt_o && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("gnt_idle", 32'(gnt_o), 32'd1);
    @(posedge clk); #1;
    req_i = 1'b0; we_i = ~w; addr_i = $urandom; wdata_i = $urandom;
    @(negedge clk);
    chk("setup_psel", 32'(psel_o), 32'(esel));
    chk("setup_penable", 32'(penable_o), 32'd0);
    chk("setup_paddr", paddr_o, mapped ? a : '0);
    chk("setup_pwrite", 32'(pwrite_o), 32'(mapped && w));
    chk("setup_pwdata", pwdata_o, mapped ? d : '0);
    chk("setup_rvalid", 32'(rvalid_o), 32'd0);
    chk("busy_gnt", 32'(gnt_o), 32'd0);
    chk_bus_rules();
    if (mapped) begin
      @(negedge clk);
      chk("access_psel", 32'(psel_o), 32'(esel));
      chk("access_penable", 32'(penable_o), 32'd1);
      chk("access_paddr_stable", paddr_o, a);
      chk("access_pwdata", pwdata_o, d);
      chk("access_rvalid", 32'(rvalid_o), 32'd0);
      chk_bus_rules();
    end
    @(negedge clk);
    chk("resp_rvalid", 32'(rvalid_o), 32'd1);
    chk("resp_err", 32'(err_o), 32'(!mapped));
    chk("resp_rdata", rdata_o, erdata);
    chk("resp_psel_idle", 32'(psel_o), 32'd0);
    chk("resp_paddr_zero", paddr_o, '0);
    chk("resp_gnt", 32'(gnt_o), 32'd1);
    @(negedge clk);
    chk("rvalid_one_cycle", 32'(rvalid_o), 32'd0);
  endtask

  initial begin
    logic [XLEN-1:0] ra;
    logic            rw;
    for (int k = 0; k < NSLV; k++) slot_val[k] = '0;

    #3;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_psel", 32'(psel_o), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_penable", 32'(penable_o), 32'd0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    txn(1'b1, 32'h0000_0000, 32'hDEAD_BEEF);
    slot_val[1] = 32'h1234_5678;
    prdata_i[1*XLEN +: XLEN] = slot_val[1];
    txn(1'b0, 32'h0000_1004, 32'h0);
    txn(1'b0, 32'h0000_5000, 32'h0);
    txn(1'b0, 32'h8000_3000, 32'h0);
    txn(1'b0, 32'h0000_3FFC, 32'h0);

    // Request held high: grants every third cycle, each coinciding with a response.
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_2010; wdata_i = 32'hA5A5_0001;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      chk("b2b_gnt", 32'(gnt_o), 32'((c % 3) == 0));
      chk("b2b_rvalid", 32'(rvalid_o), 32'((c != 0) && ((c % 3) == 0)));
      chk_bus_rules();
      if (c == 6) begin
        @(posedge clk); #1;
        req_i = 1'b0;
      end
    end

    // Reset asserted during ACCESS aborts the transfer with no response.
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_2000;
    @(posedge clk); #1;
    req_i = 1'b0;
    @(posedge clk); #2;
    chk("pre_abort_penable", 32'(penable_o), 32'd1);
    rstn = 1'b0;
    #1;
    chk("abort_psel", 32'(psel_o), 32'd0);
    chk("abort_penable", 32'(penable_o), 32'd0);
    chk("abort_gnt", 32'(gnt_o), 32'd0);
    @(negedge clk);
    chk("abort_rvalid", 32'(rvalid_o), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    chk("abort_no_rvalid", 32'(rvalid_o), 32'd0);
    @(posedge clk); #1;
    load_slots();
    txn(1'b0, 32'h0000_0ABC, 32'h0);

    for (int n = 0; n < 40; n++) begin
      load_slots();
      rw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1:    ra = $urandom;
        2, 3:    ra = (32'($urandom_range(NSLV, 15)) << 12) | 32'($urandom_range(0, 4095));
        default: ra = (32'($urandom_range(0, NSLV - 1)) << 12) | 32'($urandom_range(0, 4095));
      endcase
      txn(rw, ra, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
